gate_vector_sequencer: RTL

- Controller that exercises one external 2-input logic gate, such as the team's orgate.
- On a start request it drives every input combination onto the gate, waits a configurable settle time and samples the gate output.
- Each sample is compared against the expected truth table for a selected operation; the block reports error count, first failing vector and a pass/fail verdict.
- Sits beside the gate under test, in place of a hand-written delay-driven stimulus sequence.

---
 rtl/gate_seq_pkg.sv | 41 ++++
 rtl/gate_vector_sequencer_if.sv | 32 +++
 rtl/gate_vector_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate vector sequencer.
//   op_e          : expected gate function selector
//   state_t/ST_*  : sequencer FSM encoding
//   gate_expected : reference truth table for one vector
package gate_seq_pkg;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned VEC_W    = 2;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned PASS_W   = 8;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_e;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRIVE  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_SAMPLE = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Expected gate output for inputs a,b under the selected function.
  function automatic logic gate_expected(op_e op, logic a, logic b);
    logic y;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Host/gate-side bundle of the gate vector sequencer.
//   start, op          : run request and expected function (host -> sequencer)
//   gate_a, gate_b     : vector driven onto the gate under test
//   gate_y             : gate output under test
//   busy, done, pass   : run status
//   err_count, first_fail_vec, first_fail_valid : run report
// master: host side (issues start, supplies gate_y); slave: sequencer.
interface gate_vector_sequencer_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic [1:0]       op;
  logic             gate_a;
  logic             gate_b;
  logic             gate_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, op, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, op, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Sweeps all four {a,b} vectors onto an external 2-input gate, waits
// SETTLE_CYCLES, samples gate_y and checks it against the selected function.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : gate_vector_sequencer_if.slave (start/op in, gate drive, report out)
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_vector_sequencer_if.slave  bus
);

  localparam logic [ERR_W-1:0]    ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0]   LAST_PASS   = PASS_W'(PASSES - 1);
  localparam logic [VEC_W-1:0]    LAST_VEC    = 2'd3;

  state_t              state_q, state_d;
  op_e                 op_q, op_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                gate_a_q, gate_a_d;
  logic                gate_b_q, gate_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [1:0]          ffvec_q, ffvec_d;
  logic                ffvalid_q, ffvalid_d;

  logic                mismatch_c;
  logic [ERR_W-1:0]    err_inc_c;

  // 4-state compare so an X/Z gate output is flagged as a mismatch.
  assign mismatch_c = (bus.gate_y !== gate_expected(op_q, gate_a_q, gate_b_q));
  assign err_inc_c  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

  // Next-state and report logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vec_d      = vec_q;
    pass_idx_d = pass_idx_q;
    settle_d   = settle_q;
    gate_a_d   = gate_a_q;
    gate_b_d   = gate_b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ffvec_d    = ffvec_q;
    ffvalid_d  = ffvalid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d       = op_e'(bus.op);
          err_d      = '0;
          ffvec_d    = '0;
          ffvalid_d  = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          vec_d      = '0;
          pass_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        gate_a_d = vec_q[1];
        gate_b_d = vec_q[0];
        settle_d = SETTLE_INIT;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Entered at SETTLE_CYCLES-1, so residency is exactly SETTLE_CYCLES.
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          err_d = err_inc_c;
          if (!ffvalid_q) begin
            ffvec_d   = {gate_a_q, gate_b_q};
            ffvalid_d = 1'b1;
          end
        end
        if (vec_q != LAST_VEC) begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_DRIVE;
        end else if (pass_idx_q != LAST_PASS) begin
          vec_d      = '0;
          pass_idx_d = pass_idx_q + PASS_W'(1);
          state_d    = ST_DRIVE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_OR;
      vec_q      <= '0;
      pass_idx_q <= '0;
      settle_q   <= '0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffvec_q    <= '0;
      ffvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      vec_q      <= vec_d;
      pass_idx_q <= pass_idx_d;
      settle_q   <= settle_d;
      gate_a_q   <= gate_a_d;
      gate_b_q   <= gate_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ffvec_q    <= ffvec_d;
      ffvalid_q  <= ffvalid_d;
    end
  end

  assign bus.gate_a           = gate_a_q;
  assign bus.gate_b           = gate_b_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.first_fail_valid = ffvalid_q;

endmodule
